// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multicycle MIPS-style control FSM with memory wait timeout
// Optional: define MC_ILLEGAL_TRAP_EN to trap undecoded instructions (err=01).
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       retire,
  output logic       halted,
  output logic [1:0] err
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    LWB    = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  RWB   = 4'd7,
    EXEC_I = 4'd8,  IWB    = 4'd9,  BRANCH = 4'd10, JUMP  = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state, nxt_state;
  logic [7:0] wait_cnt;
  logic [1:0] err_q, err_d;

  logic is_rtype, r_alu, is_jr, is_lw, is_sw, is_jal, is_j;
  logic is_addi, is_xori, is_beq, is_bne, is_mem_state, mem_to;

  assign is_rtype = (op == 6'h00);
  assign r_alu    = is_rtype && (funct == 6'h20 || funct == 6'h22 ||
                                 funct == 6'h26 || funct == 6'h2A);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);
  assign is_addi  = (op == 6'h08);
  assign is_xori  = (op == 6'h0E);
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);

  assign is_mem_state = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
  // This cycle is the MEM_TIMEOUT-th consecutive wait cycle with no completion.
  assign mem_to = (wait_cnt == TIMEOUT_LAST) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      wait_cnt  <= 8'd0;
      err_q     <= 2'b00;
    end else begin
      cur_state <= nxt_state;
      err_q     <= err_d;
      if (nxt_state != cur_state)
        wait_cnt <= 8'd0;
      else if (is_mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    err_d     = err_q;
    pc_en     = 1'b0;
    pc_src    = 2'b00;
    ir_wr     = 1'b0;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_wr     = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) nxt_state = DECODE;
        else if (mem_to) begin
          nxt_state = TRAP;
          err_d     = 2'b10;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (is_lw || is_sw)             nxt_state = MEMADR;
        else if (r_alu)                 nxt_state = EXEC_R;
        else if (is_jr || is_j || is_jal) nxt_state = JUMP;
        else if (is_addi || is_xori)    nxt_state = EXEC_I;
        else if (is_beq || is_bne)      nxt_state = BRANCH;
        else begin
`ifdef MC_ILLEGAL_TRAP_EN
          nxt_state = TRAP;
          err_d     = 2'b01;
`else
          // Undecoded instructions retire as a NOP.
          nxt_state = FETCH;
          retire    = 1'b1;
`endif
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = is_lw ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) nxt_state = LWB;
        else if (mem_to) begin
          nxt_state = TRAP;
          err_d     = 2'b10;
        end
      end
      LWB: begin
        reg_wr    = 1'b1;
        wb_src    = 2'b01;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = FETCH;
        end else if (mem_to) begin
          nxt_state = TRAP;
          err_d     = 2'b10;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          6'h22:   alu_op = ALU_SUB;
          6'h26:   alu_op = ALU_XOR;
          6'h2A:   alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        nxt_state = RWB;
      end
      RWB: begin
        reg_wr    = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = is_xori ? ALU_XOR : ALU_ADD;
        nxt_state = IWB;
      end
      IWB: begin
        reg_wr    = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = is_beq ? zero : !zero;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      JUMP: begin
        pc_en  = 1'b1;
        pc_src = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          // Writes the PC+4 value latched during FETCH into r31.
          reg_wr  = 1'b1;
          reg_dst = 2'b10;
          wb_src  = 2'b10;
        end
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      TRAP:    nxt_state = TRAP;
      default: nxt_state = FETCH;
    endcase
  end

  assign state  = cur_state;
  assign halted = (cur_state == TRAP);
  assign err    = err_q;

endmodule

`default_nettype wire
